fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester, grant and FIFO write-port signals shared by the
// write-side arbiter and its environment.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 3,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic [NUM_REQ-1:0]            gnt;
    logic                          busy;
    logic                          fifo_full;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         w_data;

    // Arbiter side
    modport master (
        input  req, req_data, fifo_full,
        output ack, gnt, busy, w_en, w_data
    );

    // Requesters plus FIFO side
    modport slave (
        output req, req_data, fifo_full,
        input  ack, gnt, busy, w_en, w_data
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters;
// each grant owns the port for a burst of up to BURST_LEN words.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 3,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    logic [0:0]         state_q,    state_d;
    logic [IDX_W-1:0]   gnt_idx_q,  gnt_idx_d;
    logic [IDX_W-1:0]   last_idx_q, last_idx_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [NUM_REQ-1:0] gnt_q,      gnt_d;

    logic [IDX_W:0]        cand;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_valid;
    logic                  in_burst;
    logic                  owner_req;
    logic                  accept;
    logic [DATA_WIDTH-1:0] slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search starting one past the previous owner.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        cand      = '0;
        sel_idx   = '0;
        sel_valid = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = {1'b0, last_idx_q} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!sel_valid && bus.req[cand[IDX_W-1:0]]) begin
                sel_valid = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign in_burst  = (state_q == ST_BURST);
    assign owner_req = bus.req[gnt_idx_q];
    // A word presented during the reset cycle belongs to an abandoned burst.
    assign accept    = in_burst && owner_req && !bus.fifo_full && !rst;

    always_comb begin
        bus.w_en   = accept;
        bus.ack    = '0;
        bus.w_data = '0;
        if (accept) begin
            bus.ack[gnt_idx_q] = 1'b1;
        end
        if (in_burst) begin
            bus.w_data = slice[gnt_idx_q];
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.busy = in_burst;

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    gnt_idx_d        = sel_idx;
                    gnt_d            = '0;
                    gnt_d[sel_idx]   = 1'b1;
                    cnt_d            = '0;
                    state_d          = ST_BURST;
                end
            end
            ST_BURST: begin
                // Release wins over a full FIFO; a full FIFO alone just stalls.
                if (!owner_req) begin
                    state_d    = ST_IDLE;
                    last_idx_d = gnt_idx_q;
                    gnt_d      = '0;
                end else if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d    = ST_IDLE;
                        last_idx_d = gnt_idx_q;
                        gnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // pre-edge values; reset is synchronous and covers all state (no memories here).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_idx_q  <= '0;
            last_idx_q <= IDX_LAST;
            cnt_q      <= '0;
            gnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a directed vector table, scenario
// sequences and randomized traffic against an owner/words-left reference model.
module tb_fifo_wr_arbiter;
    localparam int DW = 3;
    localparam int NR = 4;
    localparam int BL = 4;

    logic clk;
    logic rst;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: who owns the port (-1 when idle) and how many words remain.
    int m_owner = -1;
    int m_left  = 0;
    int m_last  = NR - 1;

    function automatic int rr_pick(input logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++) begin
            if (r[(m_last + k) % NR]) return (m_last + k) % NR;
        end
        return -1;
    endfunction

    logic [NR-1:0] g_gnt, g_ack;
    logic          g_busy, g_w_en;
    logic [DW-1:0] g_w_data;

    task automatic cycle(input logic r, input logic [NR-1:0] rq, input logic [NR*DW-1:0] d,
                         input logic f, input bit cmp, input string tag);
        logic [NR-1:0] e_gnt, e_ack;
        logic          e_busy, e_wen;
        logic [DW-1:0] e_wd;
        bit            acc;
        @(negedge clk);
        rst           = r;
        bus.req       = rq;
        bus.req_data  = d;
        bus.fifo_full = f;
        #1;
        g_gnt    = bus.gnt;
        g_ack    = bus.ack;
        g_busy   = bus.busy;
        g_w_en   = bus.w_en;
        g_w_data = bus.w_data;

        e_busy = (m_owner >= 0);
        e_gnt  = '0;
        e_wd   = '0;
        acc    = 1'b0;
        if (e_busy) begin
            e_gnt[m_owner] = 1'b1;
            e_wd           = d[m_owner*DW +: DW];
            acc            = rq[m_owner] && !f && !r;
        end
        e_wen = acc;
        e_ack = acc ? e_gnt : '0;

        if (cmp) begin
            check({tag, "_gnt"},    32'(g_gnt),    32'(e_gnt));
            check({tag, "_busy"},   32'(g_busy),   32'(e_busy));
            check({tag, "_w_en"},   32'(g_w_en),   32'(e_wen));
            check({tag, "_ack"},    32'(g_ack),    32'(e_ack));
            check({tag, "_w_data"}, 32'(g_w_data), 32'(e_wd));
        end

        if (r) begin
            m_owner = -1;
            m_last  = NR - 1;
        end else if (m_owner < 0) begin
            if (rq != '0) begin
                m_owner = rr_pick(rq);
                m_left  = BL;
            end
        end else if (!rq[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (acc) begin
            m_left--;
            if (m_left == 0) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    typedef struct {
        logic          rst;
        logic [NR-1:0] req;
        logic [11:0]   data;
        logic          full;
        logic [NR-1:0] gnt;
        logic          busy;
        logic          w_en;
        logic [NR-1:0] ack;
        logic [DW-1:0] w_data;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [11:0] d,
                                input logic f, input logic [3:0] gn, input logic bz,
                                input logic we, input logic [3:0] ak, input logic [2:0] wd);
        vec_t v;
        v.rst = r; v.req = rq; v.data = d; v.full = f;
        v.gnt = gn; v.busy = bz; v.w_en = we; v.ack = ak; v.w_data = wd;
        return v;
    endfunction

    vec_t vecs [19];

    initial begin
        logic [DW-1:0] src [4];
        logic [DW-1:0] got_q [$];
        int            ptr, accepted, stall_cycles, writes, bursts, last_start, burst_writes;
        bit            prev_busy, found;
        int            exp_order [5];

        // Single requester, 6 words split 4 + 2, then full while arbitrating.
        vecs[0]  = mk(1, 4'b0000, 12'h000, 0, 4'b0000, 0, 0, 4'b0000, 3'd0);
        vecs[1]  = mk(0, 4'b0001, 12'h001, 0, 4'b0000, 0, 0, 4'b0000, 3'd0);
        vecs[2]  = mk(0, 4'b0001, 12'h001, 0, 4'b0001, 1, 1, 4'b0001, 3'd1);
        vecs[3]  = mk(0, 4'b0001, 12'h002, 0, 4'b0001, 1, 1, 4'b0001, 3'd2);
        vecs[4]  = mk(0, 4'b0001, 12'h003, 0, 4'b0001, 1, 1, 4'b0001, 3'd3);
        vecs[5]  = mk(0, 4'b0001, 12'h004, 0, 4'b0001, 1, 1, 4'b0001, 3'd4);
        vecs[6]  = mk(0, 4'b0001, 12'h005, 0, 4'b0000, 0, 0, 4'b0000, 3'd0);
        vecs[7]  = mk(0, 4'b0001, 12'h005, 0, 4'b0001, 1, 1, 4'b0001, 3'd5);
        vecs[8]  = mk(0, 4'b0001, 12'h006, 0, 4'b0001, 1, 1, 4'b0001, 3'd6);
        vecs[9]  = mk(0, 4'b0000, 12'h000, 0, 4'b0001, 1, 0, 4'b0000, 3'd0);
        vecs[10] = mk(0, 4'b0000, 12'h000, 0, 4'b0000, 0, 0, 4'b0000, 3'd0);
        vecs[11] = mk(0, 4'b0100, 12'h1C0, 1, 4'b0000, 0, 0, 4'b0000, 3'd0);
        vecs[12] = mk(0, 4'b0100, 12'h1C0, 1, 4'b0100, 1, 0, 4'b0000, 3'd7);
        vecs[13] = mk(0, 4'b0100, 12'h1C0, 1, 4'b0100, 1, 0, 4'b0000, 3'd7);
        vecs[14] = mk(0, 4'b0100, 12'h040, 0, 4'b0100, 1, 1, 4'b0100, 3'd1);
        vecs[15] = mk(0, 4'b0100, 12'h080, 0, 4'b0100, 1, 1, 4'b0100, 3'd2);
        vecs[16] = mk(0, 4'b0100, 12'h0C0, 0, 4'b0100, 1, 1, 4'b0100, 3'd3);
        vecs[17] = mk(0, 4'b0100, 12'h100, 0, 4'b0100, 1, 1, 4'b0100, 3'd4);
        vecs[18] = mk(0, 4'b0000, 12'h000, 0, 4'b0000, 0, 0, 4'b0000, 3'd0);

        rst = 1'b1; bus.req = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
        cycle(1, '0, '0, 0, 0, "init");

        for (int i = 0; i < 19; i++) begin
            cycle(vecs[i].rst, vecs[i].req, vecs[i].data, vecs[i].full, 0, "vec");
            check($sformatf("vec%0d_gnt", i),    32'(g_gnt),    32'(vecs[i].gnt));
            check($sformatf("vec%0d_busy", i),   32'(g_busy),   32'(vecs[i].busy));
            check($sformatf("vec%0d_w_en", i),   32'(g_w_en),   32'(vecs[i].w_en));
            check($sformatf("vec%0d_ack", i),    32'(g_ack),    32'(vecs[i].ack));
            check($sformatf("vec%0d_w_data", i), 32'(g_w_data), 32'(vecs[i].w_data));
        end

        // Round robin with every requester asserted.
        exp_order = '{0, 1, 2, 3, 0};
        cycle(1, '0, '0, 0, 1, "rr_rst");
        bursts = 0; last_start = 0; burst_writes = 0; prev_busy = 1'b0;
        for (int c = 0; c < 30; c++) begin
            cycle(0, 4'b1111, 12'($urandom_range(0, 4095)), 0, 1, "rr");
            if (g_busy && !prev_busy) begin
                if (bursts < 5) begin
                    check($sformatf("rr_order%0d", bursts), 32'(g_gnt), 32'(1 << exp_order[bursts]));
                    if (bursts > 0) check($sformatf("rr_spacing%0d", bursts), 32'(c - last_start), 32'd5);
                end
                bursts++;
                last_start   = c;
                burst_writes = 0;
            end
            if (g_w_en) burst_writes++;
            if (!g_busy && prev_busy) check("rr_burst_len", 32'(burst_writes), 32'(BL));
            prev_busy = g_busy;
        end
        check("rr_bursts_seen", 32'(bursts >= 5), 32'd1);

        // Backpressure: FIFO full for 3 cycles after the 2nd accepted word.
        src = '{3'd5, 3'd2, 3'd7, 3'd1};
        cycle(1, '0, '0, 0, 1, "bp_rst");
        ptr = 0; accepted = 0; stall_cycles = 0;
        got_q.delete();
        for (int c = 0; c < 20; c++) begin
            logic f;
            logic [NR-1:0] rq;
            logic [11:0]   d;
            f  = (accepted >= 2) && (stall_cycles < 3);
            rq = (ptr < 4) ? 4'b0010 : 4'b0000;
            d  = (ptr < 4) ? (12'(src[ptr]) << DW) : 12'h000;
            cycle(0, rq, d, f, 1, "bp");
            if (f) begin
                stall_cycles++;
                check("bp_stall_w_en", 32'(g_w_en), 32'd0);
                check("bp_stall_ack",  32'(g_ack),  32'd0);
            end
            if (g_w_en) got_q.push_back(g_w_data);
            if (g_ack[1]) begin
                ptr++;
                accepted++;
            end
        end
        check("bp_write_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) check($sformatf("bp_word%0d", i), 32'(got_q[i]), 32'(src[i]));
        end
        check("bp_busy_end", 32'(g_busy), 32'd0);

        // Early release by requester 2: next grant goes to 3, or wraps to 0.
        for (int v = 0; v < 2; v++) begin
            logic [NR-1:0] others;
            others = (v == 0) ? 4'b1011 : 4'b0011;
            cycle(1, '0, '0, 0, 1, "er_rst");
            cycle(0, 4'b0100, 12'h0C0, 0, 1, "er");
            writes = 0;
            for (int c = 0; c < 2; c++) begin
                cycle(0, 4'b0100, 12'($urandom_range(0, 4095)), 0, 1, "er");
                if (g_w_en && g_ack[2]) writes++;
            end
            cycle(0, others, 12'($urandom_range(0, 4095)), 0, 1, "er");
            if (g_w_en) writes++;
            check($sformatf("er%0d_writes", v), 32'(writes), 32'd2);
            cycle(0, others, 12'($urandom_range(0, 4095)), 0, 1, "er");
            check($sformatf("er%0d_idle_gnt", v), 32'(g_gnt), 32'd0);
            cycle(0, others, 12'($urandom_range(0, 4095)), 0, 1, "er");
            check($sformatf("er%0d_next_gnt", v), 32'(g_gnt), (v == 0) ? 32'h8 : 32'h1);
        end

        // Reset during cnt=2 of a burst to requester 1.
        cycle(1, '0, '0, 0, 1, "mr_rst");
        writes = 0; found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            cycle(0, 4'b0011, 12'($urandom_range(0, 4095)), 0, 1, "mr");
            if (g_ack[1]) writes++;
            if (writes == 2) found = 1'b1;
        end
        check("mr_reached_cnt2", 32'(found), 32'd1);
        cycle(1, 4'b0011, 12'($urandom_range(0, 4095)), 0, 1, "mr_hit");
        check("mr_rst_cycle_w_en", 32'(g_w_en), 32'd0);
        cycle(0, 4'b0011, 12'($urandom_range(0, 4095)), 0, 1, "mr_after");
        check("mr_after_gnt",  32'(g_gnt),  32'd0);
        check("mr_after_busy", 32'(g_busy), 32'd0);
        check("mr_after_w_en", 32'(g_w_en), 32'd0);
        cycle(0, 4'b0011, 12'($urandom_range(0, 4095)), 0, 1, "mr_regrant");
        check("mr_first_gnt", 32'(g_gnt), 32'd1);

        // Randomized traffic against the reference model.
        cycle(1, '0, '0, 0, 1, "rnd_rst");
        for (int c = 0; c < 800; c++) begin
            cycle($urandom_range(0, 199) == 0,
                  4'($urandom_range(0, 15)),
                  12'($urandom_range(0, 4095)),
                  $urandom_range(0, 3) == 0,
                  1, "rnd");
            if (g_w_en && bus.fifo_full) check("rnd_w_en_while_full", 32'(g_w_en), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
